cla_serial_adder_ctrl: RTL and testbench



---
 rtl/cla_pkg.sv | 13 +
 rtl/cla4.sv | 28 ++
 rtl/cla_serial_adder_ctrl.sv | 126 ++++++++++++
 tb/tb_cla_serial_adder_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the serial carry-lookahead adder controller.
package cla_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int NIBBLES_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder slice; purely combinational.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c[3:0];
    assign co = c[4];

endmodule

// File: rtl/cla_serial_adder_ctrl.sv
// Wide adder built by stepping one cla4 slice across the operands, LSB nibble
// first, with the inter-nibble carry held in a register.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; result registers hold the last sum
//   RUN   | one nibble per cycle through the shared cla4
//   DONE  | one-cycle done pulse; start here begins the next add at once
module cla_serial_adder_ctrl
    import cla_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [NIBBLE_W*NIBBLES-1:0]   a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   b,
    input  logic                          ci,
    output logic                          busy,
    output logic                          done,
    output logic [NIBBLE_W*NIBBLES-1:0]   s,
    output logic                          co
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int CNT_W = $clog2(NIBBLES);

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic [CNT_W-1:0]     cnt;
    logic                 last_nib;
    logic [W-1:0]         a_r;
    logic [W-1:0]         b_r;
    logic                 c_r;
    logic [W-1:0]         s_w;
    logic [W-1:0]         s_next;
    logic [NIBBLE_W-1:0]  nib_s;
    logic                 nib_co;

    assign last_nib = (cnt == CNT_W'(NIBBLES - 1));

    cla4 u_cla4 (
        .a  (a_r[NIBBLE_W*cnt +: NIBBLE_W]),
        .b  (b_r[NIBBLE_W*cnt +: NIBBLE_W]),
        .ci (c_r),
        .s  (nib_s),
        .co (nib_co)
    );

    // Working sum with the current nibble merged in; becomes the result on the last nibble.
    always_comb begin
        s_next = s_w;
        s_next[NIBBLE_W*cnt +: NIBBLE_W] = nib_s;
    end

    // Next-state decode; start is only looked at in IDLE and DONE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_nib) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, nibble stepping and result update (result only moves on the last nibble).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
            c_r <= 1'b0;
            a_r <= '0;
            b_r <= '0;
            s_w <= '0;
            s   <= '0;
            co  <= 1'b0;
        end else if (accept) begin
            a_r <= a;
            b_r <= b;
            c_r <= ci;
            cnt <= '0;
        end else if (state == RUN) begin
            s_w <= s_next;
            c_r <= nib_co;
            if (last_nib) begin
                s  <= s_next;
                co <= nib_co;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Status flags are pure decodes of the state register.
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// Scoreboard bench for cla_serial_adder_ctrl: expected sums and completion
// cycles are queued at issue and retired when done pulses.
module tb_cla_serial_adder_ctrl;

    localparam int N = 8;
    localparam int W = 4 * N;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   n_done   = 0;
    int   busy_len = 0;
    logic prev_done = 1'b0;
    exp_t sb[$];

    cla_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ci      (ci),
        .busy    (busy),
        .done    (done),
        .s       (s),
        .co      (co)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Retire one scoreboard entry per done pulse and check pulse shape and latency.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            check("busy_done_excl", {63'd0, busy}, 64'd0);
            check("done_pulse", {63'd0, prev_done}, 64'd0);
            check("busy_len", 64'(busy_len), 64'(N));
            check("sb_occupancy", {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sum", 64'(s), 64'(e.s));
                check("carry_out", {63'd0, co}, {63'd0, e.co});
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
            busy_len = 0;
            n_done++;
        end else if (busy) begin
            busy_len++;
        end else begin
            busy_len = 0;
        end
        prev_done = done;
    end

    // Drive one request; the accept edge is the next rising edge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tci, input bit push);
        exp_t e;
        logic [W:0] sum;
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb;
        ci    = tci;
        sum   = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tci};
        e.s   = sum[W-1:0];
        e.co  = sum[W];
        e.cyc = cyc + 1 + N;
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        ci    = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int target);
        int i;
        for (i = 0; i < 4 * (N + 2); i++) begin
            if (n_done >= target) break;
            @(posedge clk);
        end
        check("done_timeout", 64'(n_done >= target ? target : n_done), 64'(target));
    endtask

    initial begin
        exp_t e1;
        exp_t e2;
        logic [W:0] sum;

        reset_n = 1'b0;
        start   = 1'b1;
        a       = '1;
        b       = '1;
        ci      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s", 64'(s), 64'd0);
        check("rst_co", {63'd0, co}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        reset_n = 1'b1;
        start   = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {63'd0, busy}, 64'd0);

        issue(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1);
        wait_done(n_done + 1);

        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
        wait_done(n_done + 1);

        // Start pulse with different operands in the middle of RUN must be ignored.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1;
        a     = 32'h0000_0001;
        b     = 32'h0000_0001;
        check("mid_run_busy", {63'd0, busy}, 64'd1);
        check("s_hold", 64'(s), 64'd0);
        check("co_hold", {63'd0, co}, 64'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done(n_done + 1);

        // Reset in the middle of RUN discards the operation.
        issue(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst_s", 64'(s), 64'd0);
        check("midrst_co", {63'd0, co}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        repeat (N + 3) @(negedge clk);

        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        wait_done(n_done + 1);

        // Back-to-back: start held high, second add accepted in DONE.
        @(negedge clk);
        start  = 1'b1;
        a      = 32'h7FFF_FFFF;
        b      = 32'h0000_0001;
        ci     = 1'b0;
        sum    = {1'b0, a} + {1'b0, b};
        e1.s   = sum[W-1:0];
        e1.co  = sum[W];
        e1.cyc = cyc + 1 + N;
        sb.push_back(e1);
        @(negedge clk);
        a      = 32'h8000_0000;
        b      = 32'h8000_0000;
        ci     = 1'b1;
        sum    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        e2.s   = sum[W-1:0];
        e2.co  = sum[W];
        e2.cyc = e1.cyc + N + 1;
        sb.push_back(e2);
        wait_done(n_done + 1);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(n_done + 1);

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
